// File: rtl/mode_batch_sched.sv
// Batch scheduler for the shared histogram mode-finder.
// Each batch clears the histogram, streams exactly len_q samples from two
// requesters through a round-robin arbiter, waits for the unit to settle,
// then latches the mode and pulses done.
module mode_batch_sched #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] batch_len,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             mf_rst,
  output logic             mf_next,
  output logic [7:0]       mf_number,
  input  logic [7:0]       mf_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       mode,
  output logic [LEN_W-1:0] sample_cnt
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              mf_next_q, mf_next_d;
  logic [DATA_W-1:0] mf_number_q, mf_number_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mode_q, mode_d;

  logic              in_run_c;
  logic              grant_c;
  logic              xfer_c;
  logic [DATA_W-1:0] xfer_data_c;
  logic [LEN_W-1:0]  cnt_inc_c;

  // Round-robin grant: a lone requester always wins; contention goes to the
  // one not served last. With nobody valid the grant still points somewhere.
  always_comb begin
    grant_c = ~last_grant_q;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end else if (req0_valid) begin
      grant_c = 1'b0;
    end
  end

  // Handshake decode: only RUN offers ready, and only to the granted side.
  always_comb begin
    in_run_c    = (state_q == S_RUN);
    xfer_c      = in_run_c && (grant_c ? req1_valid : req0_valid);
    xfer_data_c = grant_c ? req1_data : req0_data;
    cnt_inc_c   = cnt_q + LEN_W'(1);
  end

  // Next-state and register-input logic for the batch sequence.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mf_next_d    = 1'b0;
    mf_number_d  = mf_number_q;
    done_d       = 1'b0;
    mode_d       = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = batch_len;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = (len_q != '0) ? S_RUN : S_CAPTURE;
      end
      S_RUN: begin
        if (xfer_c) begin
          mf_number_d  = xfer_data_c;
          mf_next_d    = 1'b1;
          last_grant_d = grant_c;
          cnt_d        = cnt_inc_c;
          if (cnt_inc_c == len_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        mode_d  = mf_out;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mf_next_q    <= 1'b0;
      mf_number_q  <= '0;
      done_q       <= 1'b0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mf_next_q    <= mf_next_d;
      mf_number_q  <= mf_number_d;
      done_q       <= done_d;
      mode_q       <= mode_d;
    end
  end

  // Histogram reset follows scheduler reset so an aborted batch leaves no residue.
  assign mf_rst     = rst || (state_q == S_CLEAR);
  assign req0_ready = in_run_c && !grant_c;
  assign req1_ready = in_run_c && grant_c;
  assign mf_next    = mf_next_q;
  assign mf_number  = mf_number_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign mode       = mode_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mode_batch_sched.sv
// Directed bench for mode_batch_sched with a behavioural histogram mode-finder.
module tb_mode_batch_sched;

  localparam int unsigned LEN_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic [LEN_W-1:0] batch_len;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             mf_rst, mf_next;
  logic [7:0]       mf_number, mf_out, mode;
  logic             busy, done;
  logic [LEN_W-1:0] sample_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Sample source FIFOs for each requester.
  logic [7:0] buf0 [64];
  logic [7:0] buf1 [64];
  int head0 = 0, head1 = 0, tail0 = 0, tail1 = 0;
  logic en0 = 1'b0, en1 = 1'b0, flush_q = 1'b0;

  assign req0_valid = en0 && (head0 != tail0);
  assign req1_valid = en1 && (head1 != tail1);
  assign req0_data  = buf0[head0 % 64];
  assign req1_data  = buf1[head1 % 64];

  // Pop on handshake, or drop leftovers on request.
  always @(posedge clk) begin
    if (flush_q) begin
      head0 <= tail0;
      head1 <= tail1;
    end else begin
      if (req0_valid && req0_ready) head0 <= head0 + 1;
      if (req1_valid && req1_ready) head1 <= head1 + 1;
    end
  end

  // Behavioural mode-finder: counts per value, lowest value wins a tie.
  int hist [256];
  always @(posedge clk) begin
    if (mf_rst) begin
      for (int v = 0; v < 256; v++) hist[v] <= 0;
    end else if (mf_next) begin
      hist[mf_number] <= hist[mf_number] + 1;
    end
  end

  logic [7:0] best;
  int         bestc;
  always_comb begin
    best  = 8'd0;
    bestc = 0;
    for (int v = 0; v < 256; v++) begin
      if (hist[v] > bestc) begin
        bestc = hist[v];
        best  = 8'(v);
      end
    end
  end
  assign mf_out = best;

  // Cycle counter and event logs.
  int         cyc = 0;
  logic [7:0] nxt_log [256];
  int         nxt_n = 0;
  int         gnt_log [256];
  int         gnt_n = 0;
  int         rst_cnt = 0;
  int         acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mf_next) begin
      nxt_log[nxt_n % 256] <= mf_number;
      nxt_n <= nxt_n + 1;
    end
    if (mf_rst) rst_cnt <= rst_cnt + 1;
    if (req0_valid && req0_ready) begin
      gnt_log[gnt_n % 256] <= 0;
      gnt_n   <= gnt_n + 1;
      acc_cyc <= cyc;
    end else if (req1_valid && req1_ready) begin
      gnt_log[gnt_n % 256] <= 1;
      gnt_n   <= gnt_n + 1;
      acc_cyc <= cyc;
    end
  end

  mode_batch_sched #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .batch_len  (batch_len),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .mf_rst     (mf_rst),
    .mf_next    (mf_next),
    .mf_number  (mf_number),
    .mf_out     (mf_out),
    .busy       (busy),
    .done       (done),
    .mode       (mode),
    .sample_cnt (sample_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] v);
    buf0[tail0 % 64] = v;
    tail0 = tail0 + 1;
  endtask

  task automatic push1(input logic [7:0] v);
    buf1[tail1 % 64] = v;
    tail1 = tail1 + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic launch(input logic [LEN_W-1:0] len);
    tick();
    start = 1'b1;
    batch_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int dc);
    int i;
    seen = 1'b0;
    dc = 0;
    i = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        dc = cyc;
      end
      i++;
    end
    #1;
  endtask

  task automatic wait_cnt(input logic [LEN_W-1:0] val, input int budget, output bit seen);
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (sample_cnt === val) seen = 1'b1;
      i++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; batch_len = '0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (mf_rst !== 1'b1) begin n_bad++; $display("FAIL reset_mf_rst got %b want 1", mf_rst); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (mode !== 8'h00) begin n_bad++; $display("FAIL reset_mode got %h want 00", mode); end
    n_cmp++; if (sample_cnt !== LEN_W'(0)) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
    n_cmp++; if ({mf_next, mf_number} !== 9'h000) begin n_bad++; $display("FAIL reset_mf got %b/%h want 0/00", mf_next, mf_number); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mf_rst !== 1'b0) begin n_bad++; $display("FAIL idle_mf_rst got %b want 0", mf_rst); end
  endtask

  task automatic test_single_stream();
    bit seen;
    int dc, nb, rb;
    logic [7:0] exp1 [5];
    exp1[0] = 8'd3; exp1[1] = 8'd7; exp1[2] = 8'd3; exp1[3] = 8'd9; exp1[4] = 8'd3;
    #1;
    nb = nxt_n;
    rb = rst_cnt;
    for (int i = 0; i < 5; i++) push0(exp1[i]);
    en0 = 1'b1;
    launch(LEN_W'(5));
    wait_done(100, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL stream_done got %b want 1", seen); end
    n_cmp++; if (dc - acc_cyc !== 3) begin n_bad++; $display("FAIL stream_latency got %0d want 3", dc - acc_cyc); end
    n_cmp++; if (mode !== 8'd3) begin n_bad++; $display("FAIL stream_mode got %h want 03", mode); end
    n_cmp++; if (sample_cnt !== LEN_W'(5)) begin n_bad++; $display("FAIL stream_cnt got %0d want 5", sample_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_busy_at_done got %b want 0", busy); end
    n_cmp++; if (rst_cnt - rb !== 1) begin n_bad++; $display("FAIL stream_clear_cycles got %0d want 1", rst_cnt - rb); end
    n_cmp++; if (nxt_n - nb !== 5) begin n_bad++; $display("FAIL stream_next_count got %0d want 5", nxt_n - nb); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (nxt_log[(nb + i) % 256] !== exp1[i]) begin
        n_bad++; $display("FAIL stream_number[%0d] got %h want %h", i, nxt_log[(nb + i) % 256], exp1[i]);
      end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stream_done_pulse got %b want 0", done); end
    en0 = 1'b0;
  endtask

  task automatic test_round_robin();
    bit seen;
    int dc, nb, gb;
    do_reset();
    nb = nxt_n;
    gb = gnt_n;
    for (int i = 0; i < 3; i++) begin push0(8'd10); push1(8'd20); end
    en0 = 1'b1; en1 = 1'b1;
    launch(LEN_W'(3));
    wait_done(100, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rr_done got %b want 1", seen); end
    n_cmp++; if (gnt_n - gb !== 3) begin n_bad++; $display("FAIL rr_transfers got %0d want 3", gnt_n - gb); end
    n_cmp++; if ({gnt_log[gb % 256], gnt_log[(gb + 1) % 256], gnt_log[(gb + 2) % 256]} !== {32'd0, 32'd1, 32'd0})
      begin n_bad++; $display("FAIL rr_order got %0d%0d%0d want 010", gnt_log[gb % 256], gnt_log[(gb + 1) % 256], gnt_log[(gb + 2) % 256]); end
    n_cmp++; if ({nxt_log[nb % 256], nxt_log[(nb + 1) % 256], nxt_log[(nb + 2) % 256]} !== {8'd10, 8'd20, 8'd10})
      begin n_bad++; $display("FAIL rr_numbers got %0d,%0d,%0d want 10,20,10", nxt_log[nb % 256], nxt_log[(nb + 1) % 256], nxt_log[(nb + 2) % 256]); end
    n_cmp++; if (mode !== 8'd10) begin n_bad++; $display("FAIL rr_mode got %0d want 10", mode); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rr_ready_after got %b want 00", {req0_ready, req1_ready}); end
    en0 = 1'b0; en1 = 1'b0;
    flush_q = 1'b1;
    tick();
    flush_q = 1'b0;
  endtask

  task automatic test_zero_len();
    bit seen;
    int dc, nb, sc;
    nb = nxt_n;
    tick();
    start = 1'b1;
    batch_len = '0;
    sc = cyc;
    tick();
    start = 1'b0;
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL zero_done got %b want 1", seen); end
    n_cmp++; if (dc - sc !== 3) begin n_bad++; $display("FAIL zero_latency got %0d want 3", dc - sc); end
    n_cmp++; if (mode !== 8'h00) begin n_bad++; $display("FAIL zero_mode got %h want 00", mode); end
    n_cmp++; if (nxt_n - nb !== 0) begin n_bad++; $display("FAIL zero_next_count got %0d want 0", nxt_n - nb); end
    n_cmp++; if (sample_cnt !== LEN_W'(0)) begin n_bad++; $display("FAIL zero_cnt got %0d want 0", sample_cnt); end
  endtask

  task automatic test_valid_gap();
    bit seen;
    int dc, nb;
    nb = nxt_n;
    push1(8'h42); push1(8'h42);
    en1 = 1'b1;
    launch(LEN_W'(4));
    wait_cnt(LEN_W'(2), 50, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL gap_reach2 got %b want 1", seen); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (sample_cnt !== LEN_W'(2)) begin n_bad++; $display("FAIL gap_cnt[%0d] got %0d want 2", i, sample_cnt); end
      n_cmp++; if (mf_next !== 1'b0) begin n_bad++; $display("FAIL gap_next[%0d] got %b want 0", i, mf_next); end
    end
    push1(8'h42); push1(8'h42);
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL gap_done got %b want 1", seen); end
    n_cmp++; if (mode !== 8'h42) begin n_bad++; $display("FAIL gap_mode got %h want 42", mode); end
    n_cmp++; if (sample_cnt !== LEN_W'(4)) begin n_bad++; $display("FAIL gap_cnt_final got %0d want 4", sample_cnt); end
    n_cmp++; if (nxt_n - nb !== 4) begin n_bad++; $display("FAIL gap_next_count got %0d want 4", nxt_n - nb); end
    en1 = 1'b0;
  endtask

  task automatic test_mid_rst();
    bit seen;
    int dc;
    push0(8'h11); push0(8'h11);
    en0 = 1'b1;
    launch(LEN_W'(6));
    wait_cnt(LEN_W'(2), 50, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL abort_reach2 got %b want 1", seen); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mf_rst !== 1'b1) begin n_bad++; $display("FAIL abort_mf_rst got %b want 1", mf_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL abort_ready got %b want 00", {req0_ready, req1_ready}); end
    n_cmp++; if (mode !== 8'h00) begin n_bad++; $display("FAIL abort_mode got %h want 00", mode); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
    n_cmp++; if (sample_cnt !== LEN_W'(0)) begin n_bad++; $display("FAIL abort_cnt got %0d want 0", sample_cnt); end
    push0(8'h55); push0(8'h55);
    launch(LEN_W'(2));
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rerun_done got %b want 1", seen); end
    n_cmp++; if (mode !== 8'h55) begin n_bad++; $display("FAIL rerun_mode got %h want 55", mode); end
    n_cmp++; if (sample_cnt !== LEN_W'(2)) begin n_bad++; $display("FAIL rerun_cnt got %0d want 2", sample_cnt); end
    en0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit seen;
    int dc, nb;
    nb = nxt_n;
    push0(8'h21);
    en0 = 1'b1;
    launch(LEN_W'(3));
    wait_cnt(LEN_W'(1), 50, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL b2b_reach1 got %b want 1", seen); end
    tick();
    start = 1'b1;
    batch_len = LEN_W'(1);
    push0(8'h21); push0(8'h21);
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", seen); end
    n_cmp++; if (sample_cnt !== LEN_W'(3)) begin n_bad++; $display("FAIL b2b_len_kept got %0d want 3", sample_cnt); end
    n_cmp++; if (nxt_n - nb !== 3) begin n_bad++; $display("FAIL b2b_next_count got %0d want 3", nxt_n - nb); end
    n_cmp++; if (mode !== 8'h21) begin n_bad++; $display("FAIL b2b_mode_a got %h want 21", mode); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, mf_rst} !== 2'b11) begin n_bad++; $display("FAIL b2b_restart got busy/mf_rst %b want 11", {busy, mf_rst}); end
    n_cmp++; if (mode !== 8'h21) begin n_bad++; $display("FAIL b2b_mode_hold got %h want 21", mode); end
    push0(8'h77);
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL b2b_done_b got %b want 1", seen); end
    n_cmp++; if (mode !== 8'h77) begin n_bad++; $display("FAIL b2b_mode_b got %h want 77", mode); end
    n_cmp++; if (sample_cnt !== LEN_W'(1)) begin n_bad++; $display("FAIL b2b_cnt_b got %0d want 1", sample_cnt); end
    en0 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin buf0[i] = 8'h00; buf1[i] = 8'h00; end
    rst = 1'b1;
    start = 1'b0;
    batch_len = '0;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_zero_len();
    test_valid_gap();
    test_mid_rst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mode_batch_sched.md
Name: mode_batch_sched

Overview:
- Scheduler that owns the histogram mode-finder unit and shares it between two streaming requesters.
- Per batch: clears the histogram, accepts exactly batch_len bytes through a round-robin valid/ready arbiter, and forwards them as mode-finder next/number strobes.
- Waits for the unit to settle, latches its mode output, and pulses done.
- Sits between the sample sources and the mode-finder datapath; the only block that drives the mode-finder reset/next inputs.

Parameters:
- LEN_W, 8, width of batch_len and sample_cnt. Must be <= the mode finder's per-value counter width so a batch can never overflow a counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin batch; sampled only in IDLE
- batch_len  input  LEN_W  samples in batch; latched on accepted start
- req0_valid  input  1  requester 0 has data
- req0_data  input  8  requester 0 sample
- req0_ready  output  1  requester 0 transfer accepted this cycle when valid&ready
- req1_valid  input  1  requester 1 has data
- req1_data  input  8  requester 1 sample
- req1_ready  output  1  as req0_ready
- mf_rst  output  1  to mode-finder rst
- mf_next  output  1  to mode-finder next (registered)
- mf_number  output  8  to mode-finder number (registered)
- mf_out  input  8  mode-finder result
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, mode valid
- mode  output  8  latched result of last completed batch
- sample_cnt  output  LEN_W  samples accepted in current batch

Behaviour:
- Reset values:
  - state=IDLE; mf_next=0, mf_number=0; done=0, mode=0, sample_cnt=0.
  - last_grant=1, so req0 wins the first contention.
  - mf_rst = rst OR (state==CLEAR), combinational, so a scheduler reset also clears the histogram.
- IDLE:
  - start=1 -> latch batch_len into len_q, sample_cnt<=0, go CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle): mf_rst=1. Next state is RUN if len_q!=0, else CAPTURE.
- RUN, grant logic (combinational):
  - If only one valid, grant it. If both valid, grant !last_grant.
  - reqX_ready = (state==RUN) && grant==X. The other ready is 0. At most one transfer per cycle.
  - A ready may go high without its valid; no transfer occurs unless valid&ready.
- RUN, on transfer:
  - mf_number<=granted data, mf_next<=1, last_grant<=X, sample_cnt<=sample_cnt+1.
  - If no transfer, mf_next<=0 and mf_number holds.
- RUN exit: on the transfer where sample_cnt+1==len_q, go FLUSH. Readies are 0 from the next cycle, so never more than len_q samples are accepted.
- FLUSH (1 cycle): mf_next from the final transfer is high this cycle; mf_next<=0 at its end.
- CAPTURE (1 cycle): mf_out reflects all samples. At the exit edge: mode<=mf_out, done<=1, state<=IDLE.
- done is high exactly one cycle, in IDLE, and clears next cycle.
- mode holds until the next CAPTURE or rst.
- Latency: done is high in the 3rd cycle after the edge that accepted the last sample.
  - Example: last accept at edge k -> FLUSH cycle k+1, CAPTURE k+2, done k+3.
- Valid dropping mid-batch: RUN waits indefinitely; sample_cnt holds, mf_next=0.
- rst mid-batch: all state returns to reset values on that edge. mf_rst=1 during rst, so the histogram is cleared; partial batch discarded.
- start together with done: start is accepted because state is IDLE. New batch begins; mode holds the just-finished result.
- Tie behaviour in the mode is whatever the mode-finder unit produces; the scheduler only preserves sample order (arbiter order).

Test Plan:
1. rst, then start with batch_len=5, req0 streams 3,7,3,9,3 continuously -> mf_rst high exactly one cycle (CLEAR), five mf_next pulses carrying 3,7,3,9,3, done one cycle later at the stated latency, mode=3, sample_cnt=5, busy low when done high.
2. batch_len=3, req0_valid=req1_valid=1 constantly, req0_data=10, req1_data=20 -> grants in order 0,1,0, mf_number 10,20,10, mode=10; both readies low after the 3rd transfer.
3. batch_len=0 -> IDLE, CLEAR, CAPTURE; done in the 3rd cycle after start is sampled; mode=0; no mf_next pulses.
4. batch_len=4, req1 only, valid dropped for 5 cycles after 2 samples (data 0x42 x4) -> sample_cnt holds at 2, no mf_next during gap, completion after resume, mode=0x42.
5. Mid-RUN rst after 2 of 6 samples -> next cycle state IDLE, readies 0, mode=0, done=0, mf_rst high during rst. A following batch of 2x0x55 gives mode=0x55 with no residue from the aborted batch.
6. start pulsed during RUN and FLUSH -> ignored, len_q unchanged. start in the same cycle done is high -> new batch begins immediately, mode keeps the previous result until the new CAPTURE.
